// File: rtl/mac_seq_pipe_if.sv
// Operand and result handshake bundle for mac_seq_pipe.
// master = producer/consumer side, slave = the MAC unit.
interface mac_seq_pipe_if #(
    parameter int WIDTH     = 32,
    parameter int ACC_WIDTH = 2*WIDTH+8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 in_last;
    logic                 signed_mode;
    logic                 clear;
    logic [ACC_WIDTH-1:0] acc_q;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] res_q;
    logic                 res_sat;

    modport master (
        output in_valid, a, b, in_last, signed_mode, clear, out_ready,
        input  in_ready, acc_q, out_valid, res_q, res_sat
    );

    modport slave (
        input  in_valid, a, b, in_last, signed_mode, clear, out_ready,
        output in_ready, acc_q, out_valid, res_q, res_sat
    );
endinterface

// File: rtl/mac_seq_pipe.sv
// Two-stage pipelined multiply-accumulate over framed operand sequences.
// Define MAC_SAT_EN to clamp accumulation instead of wrapping.
module mac_seq_pipe #(
    parameter int WIDTH     = 32,
    parameter int ACC_WIDTH = 2*WIDTH+8
) (
    input  logic            clk,
    input  logic            reset,
    mac_seq_pipe_if.slave   bus
);
    localparam int PW = 2*WIDTH;
    localparam int XW = ACC_WIDTH+1;

    logic                 first_q, first_d;
    logic                 seq_sgn_q, seq_sgn_d;
    logic                 p_vld_q, p_vld_d;
    logic [PW-1:0]        p_q, p_d;
    logic                 p_last_q, p_last_d;
    logic                 p_sgn_q, p_sgn_d;
    logic                 p_first_q, p_first_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 sat_acc_q, sat_acc_d;
    logic [ACC_WIDTH-1:0] res_q, res_d;
    logic                 res_sat_q, res_sat_d;
    logic                 out_valid_q, out_valid_d;

    logic                 stall, adv_a, in_ready, accept, mode_eff;
    logic [PW-1:0]        a_x, b_x, prod;
    logic [ACC_WIDTH-1:0] base, sum_acc;
    logic [XW-1:0]        base_x, prod_x, sum;
    logic                 ovf, sat_now;

    // Handshake and product stage
    always_comb begin
        stall    = p_vld_q && p_last_q && out_valid_q && !bus.out_ready;
        adv_a    = p_vld_q && !stall && !bus.clear;
        in_ready = !reset && !bus.clear && (!p_vld_q || !stall);
        accept   = bus.in_valid && in_ready;
        mode_eff = first_q ? bus.signed_mode : seq_sgn_q;
        if (mode_eff) begin
            a_x = {{WIDTH{bus.a[WIDTH-1]}}, bus.a};
            b_x = {{WIDTH{bus.b[WIDTH-1]}}, bus.b};
        end else begin
            a_x = {{WIDTH{1'b0}}, bus.a};
            b_x = {{WIDTH{1'b0}}, bus.b};
        end
        prod = a_x * b_x;
    end

    // Accumulate stage; one guard bit exposes overflow
    always_comb begin
        base    = p_first_q ? '0 : acc_q;
        base_x  = p_sgn_q ? {base[ACC_WIDTH-1], base} : {1'b0, base};
        prod_x  = p_sgn_q ? {{(XW-PW){p_q[PW-1]}}, p_q}
                          : {{(XW-PW){1'b0}}, p_q};
        sum     = base_x + prod_x;
        sum_acc = sum[ACC_WIDTH-1:0];
        ovf     = 1'b0;
`ifdef MAC_SAT_EN
        if (p_sgn_q) begin
            if (sum[XW-1] != sum[XW-2]) begin
                ovf     = 1'b1;
                sum_acc = sum[XW-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                    : {1'b0, {(ACC_WIDTH-1){1'b1}}};
            end
        end else if (sum[XW-1]) begin
            ovf     = 1'b1;
            sum_acc = '1;
        end
`endif
        sat_now = ovf || (!p_first_q && sat_acc_q);
    end

    always_comb begin
        first_d     = first_q;
        seq_sgn_d   = seq_sgn_q;
        p_vld_d     = p_vld_q;
        p_d         = p_q;
        p_last_d    = p_last_q;
        p_sgn_d     = p_sgn_q;
        p_first_d   = p_first_q;
        acc_d       = acc_q;
        sat_acc_d   = sat_acc_q;
        res_d       = res_q;
        res_sat_d   = res_sat_q;
        out_valid_d = out_valid_q;

        if (accept) begin
            p_vld_d   = 1'b1;
            p_d       = prod;
            p_last_d  = bus.in_last;
            p_sgn_d   = mode_eff;
            p_first_d = first_q;
            first_d   = bus.in_last;
            seq_sgn_d = mode_eff;
        end else if (adv_a) begin
            p_vld_d = 1'b0;
        end

        if (out_valid_q && bus.out_ready)
            out_valid_d = 1'b0;

        if (adv_a) begin
            acc_d     = sum_acc;
            sat_acc_d = sat_now;
            if (p_last_q) begin
                res_d       = sum_acc;
                res_sat_d   = sat_now;
                out_valid_d = 1'b1;
            end
        end

        // Abort drops the in-flight product but leaves the held result
        if (bus.clear) begin
            p_vld_d   = 1'b0;
            acc_d     = '0;
            sat_acc_d = 1'b0;
            first_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            first_q     <= 1'b1;
            seq_sgn_q   <= 1'b0;
            p_vld_q     <= 1'b0;
            p_q         <= '0;
            p_last_q    <= 1'b0;
            p_sgn_q     <= 1'b0;
            p_first_q   <= 1'b0;
            acc_q       <= '0;
            sat_acc_q   <= 1'b0;
            res_q       <= '0;
            res_sat_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            first_q     <= first_d;
            seq_sgn_q   <= seq_sgn_d;
            p_vld_q     <= p_vld_d;
            p_q         <= p_d;
            p_last_q    <= p_last_d;
            p_sgn_q     <= p_sgn_d;
            p_first_q   <= p_first_d;
            acc_q       <= acc_d;
            sat_acc_q   <= sat_acc_d;
            res_q       <= res_d;
            res_sat_q   <= res_sat_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.acc_q     = acc_q;
    assign bus.out_valid = out_valid_q;
    assign bus.res_q     = res_q;
    assign bus.res_sat   = res_sat_q;
endmodule

// File: tb/tb_mac_seq_pipe.sv
// Directed self-checking bench for mac_seq_pipe, WIDTH=8, ACC_WIDTH=16.
// Saturation expectations follow MAC_SAT_EN.
module tb_mac_seq_pipe;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    mac_seq_pipe_if #(.WIDTH(8), .ACC_WIDTH(16)) bus_if ();

    mac_seq_pipe #(.WIDTH(8), .ACC_WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b,
                         input logic last, input logic sgn);
        bus_if.in_valid    = 1'b1;
        bus_if.a           = a;
        bus_if.b           = b;
        bus_if.in_last     = last;
        bus_if.signed_mode = sgn;
    endtask

    task automatic idle();
        bus_if.in_valid = 1'b0;
        bus_if.in_last  = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if (bus_if.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_in_ready: got %b want 0", bus_if.in_ready);
        end
        n_checks++;
        if (bus_if.acc_q !== 16'd0 || bus_if.res_q !== 16'd0 ||
            bus_if.out_valid !== 1'b0 || bus_if.res_sat !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_outs: got acc=%0d res=%0d ov=%b sat=%b want 0",
                     bus_if.acc_q, bus_if.res_q, bus_if.out_valid, bus_if.res_sat);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (bus_if.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_release_ready: got %b want 1", bus_if.in_ready);
        end
    endtask

    task automatic test_unsigned();
        bus_if.out_ready = 1'b1;
        drive(8'd3, 8'd4, 1'b0, 1'b0);
        tick();
        drive(8'd5, 8'd6, 1'b0, 1'b0);
        tick();
        drive(8'd7, 8'd8, 1'b1, 1'b0);
        n_checks++;
        if (bus_if.acc_q !== 16'd12) begin
            n_fail++;
            $display("FAIL u_acc1: got %0d want 12", bus_if.acc_q);
        end
        tick();
        idle();
        n_checks++;
        if (bus_if.acc_q !== 16'd42 || bus_if.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL u_acc2: got acc=%0d ov=%b want 42 0",
                     bus_if.acc_q, bus_if.out_valid);
        end
        tick();
        n_checks++;
        if (bus_if.acc_q !== 16'd98 || bus_if.out_valid !== 1'b1 ||
            bus_if.res_q !== 16'd98) begin
            n_fail++;
            $display("FAIL u_result: got acc=%0d ov=%b res=%0d want 98 1 98",
                     bus_if.acc_q, bus_if.out_valid, bus_if.res_q);
        end
        tick();
        n_checks++;
        if (bus_if.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL u_ov_drop: got %b want 0", bus_if.out_valid);
        end
    endtask

    task automatic test_signed_mode();
        bus_if.out_ready = 1'b1;
        drive(8'hFD, 8'd4, 1'b0, 1'b1);
        tick();
        drive(8'd127, 8'h80, 1'b1, 1'b0);
        tick();
        drive(8'd255, 8'd255, 1'b1, 1'b0);
        n_checks++;
        if (bus_if.acc_q !== 16'hFFF4) begin
            n_fail++;
            $display("FAIL s_acc1: got %h want fff4", bus_if.acc_q);
        end
        tick();
        idle();
        n_checks++;
        if (bus_if.out_valid !== 1'b1 || bus_if.res_q !== 16'hC074) begin
            n_fail++;
            $display("FAIL s_result: got ov=%b res=%h want 1 c074",
                     bus_if.out_valid, bus_if.res_q);
        end
        tick();
        n_checks++;
        if (bus_if.out_valid !== 1'b1 || bus_if.res_q !== 16'hFE01 ||
            bus_if.acc_q !== 16'hFE01) begin
            n_fail++;
            $display("FAIL s_next_unsigned: got ov=%b res=%h acc=%h want 1 fe01 fe01",
                     bus_if.out_valid, bus_if.res_q, bus_if.acc_q);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        bus_if.out_ready = 1'b0;
        drive(8'd2, 8'd3, 1'b1, 1'b0);
        tick();
        drive(8'd4, 8'd5, 1'b1, 1'b0);
        n_checks++;
        if (bus_if.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_ready_early: got %b want 1", bus_if.in_ready);
        end
        tick();
        idle();
        n_checks++;
        if (bus_if.out_valid !== 1'b1 || bus_if.res_q !== 16'd6 ||
            bus_if.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_stall: got ov=%b res=%0d rdy=%b want 1 6 0",
                     bus_if.out_valid, bus_if.res_q, bus_if.in_ready);
        end
        tick();
        n_checks++;
        if (bus_if.res_q !== 16'd6 || bus_if.in_ready !== 1'b0 ||
            bus_if.acc_q !== 16'd6) begin
            n_fail++;
            $display("FAIL bp_hold: got res=%0d rdy=%b acc=%0d want 6 0 6",
                     bus_if.res_q, bus_if.in_ready, bus_if.acc_q);
        end
        bus_if.out_ready = 1'b1;
        #1;
        n_checks++;
        if (bus_if.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_ready_release: got %b want 1", bus_if.in_ready);
        end
        tick();
        n_checks++;
        if (bus_if.out_valid !== 1'b1 || bus_if.res_q !== 16'd20) begin
            n_fail++;
            $display("FAIL bp_second: got ov=%b res=%0d want 1 20",
                     bus_if.out_valid, bus_if.res_q);
        end
        tick();
        n_checks++;
        if (bus_if.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drain: got %b want 0", bus_if.out_valid);
        end
    endtask

    task automatic test_clear();
        bus_if.out_ready = 1'b0;
        drive(8'd1, 8'd1, 1'b1, 1'b0);
        tick();
        drive(8'd2, 8'd2, 1'b0, 1'b0);
        tick();
        drive(8'd3, 8'd3, 1'b0, 1'b0);
        tick();
        drive(8'd5, 8'd5, 1'b0, 1'b0);
        bus_if.clear = 1'b1;
        #1;
        n_checks++;
        if (bus_if.in_ready !== 1'b0 || bus_if.acc_q !== 16'd4) begin
            n_fail++;
            $display("FAIL clr_block: got rdy=%b acc=%0d want 0 4",
                     bus_if.in_ready, bus_if.acc_q);
        end
        tick();
        bus_if.clear = 1'b0;
        n_checks++;
        if (bus_if.acc_q !== 16'd0 || bus_if.out_valid !== 1'b1 ||
            bus_if.res_q !== 16'd1) begin
            n_fail++;
            $display("FAIL clr_effect: got acc=%0d ov=%b res=%0d want 0 1 1",
                     bus_if.acc_q, bus_if.out_valid, bus_if.res_q);
        end
        drive(8'd2, 8'd5, 1'b0, 1'b0);
        tick();
        drive(8'd1, 8'd3, 1'b1, 1'b0);
        tick();
        idle();
        n_checks++;
        if (bus_if.acc_q !== 16'd10 || bus_if.res_q !== 16'd1) begin
            n_fail++;
            $display("FAIL clr_restart: got acc=%0d res=%0d want 10 1",
                     bus_if.acc_q, bus_if.res_q);
        end
        bus_if.out_ready = 1'b1;
        tick();
        n_checks++;
        if (bus_if.out_valid !== 1'b1 || bus_if.res_q !== 16'd13 ||
            bus_if.acc_q !== 16'd13) begin
            n_fail++;
            $display("FAIL clr_result: got ov=%b res=%0d acc=%0d want 1 13 13",
                     bus_if.out_valid, bus_if.res_q, bus_if.acc_q);
        end
        tick();
    endtask

    task automatic test_saturation();
        logic [15:0] exp_res;
        logic        exp_sat;
`ifdef MAC_SAT_EN
        exp_res = 16'd65535;
        exp_sat = 1'b1;
`else
        exp_res = 16'd64514;
        exp_sat = 1'b0;
`endif
        bus_if.out_ready = 1'b1;
        drive(8'd255, 8'd255, 1'b0, 1'b0);
        tick();
        drive(8'd255, 8'd255, 1'b1, 1'b0);
        tick();
        idle();
        tick();
        n_checks++;
        if (bus_if.out_valid !== 1'b1 || bus_if.res_q !== exp_res ||
            bus_if.res_sat !== exp_sat) begin
            n_fail++;
            $display("FAIL sat_result: got ov=%b res=%0d sat=%b want 1 %0d %b",
                     bus_if.out_valid, bus_if.res_q, bus_if.res_sat,
                     exp_res, exp_sat);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        bus_if.out_ready = 1'b0;
        drive(8'd1, 8'd2, 1'b1, 1'b0);
        tick();
        drive(8'd3, 8'd4, 1'b0, 1'b0);
        tick();
        drive(8'd5, 8'd6, 1'b0, 1'b0);
        tick();
        idle();
        n_checks++;
        if (bus_if.out_valid !== 1'b1 || bus_if.acc_q !== 16'd12) begin
            n_fail++;
            $display("FAIL rm_pre: got ov=%b acc=%0d want 1 12",
                     bus_if.out_valid, bus_if.acc_q);
        end
        reset = 1'b1;
        tick();
        n_checks++;
        if (bus_if.acc_q !== 16'd0 || bus_if.res_q !== 16'd0 ||
            bus_if.out_valid !== 1'b0 || bus_if.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rm_reset: got acc=%0d res=%0d ov=%b rdy=%b want 0 0 0 0",
                     bus_if.acc_q, bus_if.res_q, bus_if.out_valid, bus_if.in_ready);
        end
        reset = 1'b0;
        bus_if.out_ready = 1'b1;
        drive(8'd2, 8'd2, 1'b1, 1'b0);
        #1;
        n_checks++;
        if (bus_if.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rm_ready: got %b want 1", bus_if.in_ready);
        end
        tick();
        idle();
        tick();
        n_checks++;
        if (bus_if.out_valid !== 1'b1 || bus_if.res_q !== 16'd4) begin
            n_fail++;
            $display("FAIL rm_fresh: got ov=%b res=%0d want 1 4",
                     bus_if.out_valid, bus_if.res_q);
        end
        tick();
    endtask

    initial begin
        reset              = 1'b1;
        bus_if.in_valid    = 1'b0;
        bus_if.a           = '0;
        bus_if.b           = '0;
        bus_if.in_last     = 1'b0;
        bus_if.signed_mode = 1'b0;
        bus_if.clear       = 1'b0;
        bus_if.out_ready   = 1'b0;
        tick();
        tick();
        test_reset();
        test_unsigned();
        test_signed_mode();
        test_back_to_back();
        test_clear();
        test_saturation();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
